// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer/count types for the single-clock FIFO.
// The FWFT read mode is selected with the SYNC_FIFO_FWFT_EN macro.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 9;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
    typedef logic [DEF_ADDR_WIDTH:0] count_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, threshold and status bundle for sync_fifo_param.
// The master modport is the user side and the slave modport is the FIFO side.
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  W_EN;
    logic [DATA_WIDTH-1:0] I_DATA;
    logic                  R_EN;
    logic [DATA_WIDTH-1:0] O_DATA;
    logic                  O_VALID;
    logic [ADDR_WIDTH:0]   AF_THRESH;
    logic [ADDR_WIDTH:0]   AE_THRESH;
    logic                  CLR_ERR;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output W_EN, I_DATA, R_EN, AF_THRESH, AE_THRESH, CLR_ERR,
        input  O_DATA, O_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  W_EN, I_DATA, R_EN, AF_THRESH, AE_THRESH, CLR_ERR,
        output O_DATA, O_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage array with one write port and one read port.
// The read port is registered by default and combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are deliberately left uninitialised; reset only clears the read register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];

    logic unused_rd_ctrl;
    assign unused_rd_ctrl = &{1'b0, srst, rd_en};
`else
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with a fill count, almost-full/almost-empty flags and sticky error flags.
// Defining SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; otherwise reads have one cycle of latency.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic            CLK,
    input  logic            RST,
    sync_fifo_param_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0] count_reg, count_next;
    logic full_reg, full_next;
    logic empty_reg, empty_next;
    logic af_reg, af_next;
    logic ae_reg, ae_next;
    logic ovf_reg, ovf_next;
    logic unf_reg, unf_next;
    logic wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        wr_accept   = bus.W_EN && !full_reg;
        rd_accept   = bus.R_EN && !empty_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;

        if (RST) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
        end else begin
            if (wr_accept) wr_ptr_next = wr_ptr_reg + ONE;
            if (rd_accept) rd_ptr_next = rd_ptr_reg + ONE;
            case ({wr_accept, rd_accept})
                2'b10:   count_next = count_reg + ONE;
                2'b01:   count_next = count_reg - ONE;
                default: count_next = count_reg;
            endcase
            // A fresh error wins over a coincident clear so it is never lost.
            if (bus.W_EN && full_reg)  ovf_next = 1'b1;
            else if (bus.CLR_ERR)      ovf_next = 1'b0;
            if (bus.R_EN && empty_reg) unf_next = 1'b1;
            else if (bus.CLR_ERR)      unf_next = 1'b0;
        end

        // Status follows the post-edge count, so reset falls out of the same equations.
        full_next  = (count_next == DEPTH);
        empty_next = (count_next == '0);
        af_next    = (count_next >= bus.AF_THRESH);
        ae_next    = (count_next <= bus.AE_THRESH);
    end

    always_ff @(posedge CLK) begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
        full_reg   <= full_next;
        empty_reg  <= empty_next;
        af_reg     <= af_next;
        ae_reg     <= ae_next;
        ovf_reg    <= ovf_next;
        unf_reg    <= unf_next;
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (CLK),
        .srst    (RST),
        .wr_en   (wr_accept && !RST),
        .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (bus.I_DATA),
        .rd_en   (rd_accept && !RST),
        .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.O_VALID = !empty_reg;
`else
    logic o_valid_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_valid_reg <= 1'b0;
        end else begin
            o_valid_reg <= rd_accept;
        end
    end

    assign bus.O_VALID = o_valid_reg;
`endif

    assign bus.O_DATA       = rd_data;
    assign bus.COUNT        = count_reg;
    assign bus.FULL         = full_reg;
    assign bus.EMPTY        = empty_reg;
    assign bus.ALMOST_FULL  = af_reg;
    assign bus.ALMOST_EMPTY = ae_reg;
    assign bus.OVERFLOW     = ovf_reg;
    assign bus.UNDERFLOW    = unf_reg;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO.
- Generalised successor to the team's dual-clock FIFO, for same-domain buffering between pipeline stages.
- Adds over the dual-clock part:
  - programmable almost-full/almost-empty thresholds
  - exact fill count
  - sticky overflow/underflow error flags
  - compile-time first-word-fall-through (FWFT) read mode
- Storage is an internal register array; no clock-domain crossing.

Parameters:
- DATA_WIDTH, 9: word width in bits.
- ADDR_WIDTH, 10: address bits; DEPTH = 2**ADDR_WIDTH words.

Ports:
- CLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- W_EN  input  1  write request.
- I_DATA  input  DATA_WIDTH  write data.
- R_EN  input  1  read request.
- O_DATA  output  DATA_WIDTH  read data.
- O_VALID  output  1  O_DATA valid qualifier.
- AF_THRESH  input  ADDR_WIDTH+1  almost-full threshold, sampled every cycle.
- AE_THRESH  input  ADDR_WIDTH+1  almost-empty threshold, sampled every cycle.
- CLR_ERR  input  1  clears the sticky error flags.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- ALMOST_FULL  output  1  COUNT >= AF_THRESH.
- ALMOST_EMPTY  output  1  COUNT <= AE_THRESH.
- COUNT  output  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
- OVERFLOW  output  1  sticky: write attempted while full.
- UNDERFLOW  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (RST high at a rising edge):
  - Pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0.
  - ALMOST_EMPTY = 1, ALMOST_FULL = (AF_THRESH == 0).
  - O_DATA = 0, O_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Memory array is not cleared.
  - Reset mid-operation discards all stored words; the next cycle is a clean empty FIFO.
  - RST overrides every other input.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1-bit binary.
  - Memory is indexed by the low ADDR_WIDTH bits.
  - MSB toggles on wrap. Natural modulo 2**(ADDR_WIDTH+1) roll-over, no saturation.
- Write accepted iff W_EN && !FULL. Data stored at mem[wr_ptr], wr_ptr += 1.
- Read accepted iff R_EN && !EMPTY. rd_ptr += 1.
- Simultaneous W_EN and R_EN:
  - Both accepted when neither is blocked; COUNT unchanged.
  - When FULL: read accepted, write rejected (OVERFLOW set).
  - When EMPTY: write accepted, read rejected (UNDERFLOW set).
- COUNT, FULL, EMPTY, ALMOST_* are registered and reflect the state after the edge that changes the pointers.
  - They are recomputed from the next COUNT and current thresholds every cycle.
  - Threshold changes take effect one cycle later.
- Standard read mode (macro absent):
  - O_DATA <= mem[rd_ptr] on an accepted read; read latency 1 cycle.
  - O_VALID pulses 1 for exactly the cycle after each accepted read, else 0.
  - O_DATA holds its last value when no read occurs.
- Error flags:
  - OVERFLOW set on any cycle with W_EN && FULL.
  - UNDERFLOW set on any cycle with R_EN && EMPTY.
  - Both cleared by CLR_ERR.
  - If set condition and CLR_ERR coincide, the flag ends set.
- No state machine beyond the pointer/flag registers.
- The error flags form a 2-state sticky latch: CLEAR -> SET on error, SET -> CLEAR on CLR_ERR without a new error.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (FWFT read mode):
  - O_DATA = mem[rd_ptr] continuously; O_VALID = !EMPTY.
  - R_EN acts as a pop/acknowledge of the word currently shown.
  - A word written to an empty FIFO appears on O_DATA with O_VALID = 1 one cycle after the write edge.
  - After a pop, the next word is visible in the following cycle.
  - Flag, COUNT and error rules are unchanged.
- Undefined: standard registered read mode as described in Behaviour.

Decomposition:
- Package sync_fifo_pkg contains:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - a ptr_t typedef helper (ADDR_WIDTH+1 bits)
  - a count_t typedef helper (ADDR_WIDTH+1 bits)
- One sub-module, sync_fifo_mem:
  - register array with a write port
  - a read port that is registered or combinational depending on SYNC_FIFO_FWFT_EN
- Top module holds pointers, COUNT, flags and error latches.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, DEPTH=8, AF_THRESH=6, AE_THRESH=2):
1. Reset, then idle -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, O_VALID=0, OVERFLOW=0, UNDERFLOW=0.
2. Write 0x01..0x08 on 8 consecutive cycles:
   - ALMOST_EMPTY drops after the 3rd write; ALMOST_FULL rises after the 6th; FULL=1 and COUNT=8 after the 8th.
   - 9th write of 0xFF -> OVERFLOW=1 and memory unchanged.
   - Then read 8 words -> O_DATA = 0x01..0x08 in order, each one cycle after its R_EN.
3. Fill 4, then 20 cycles of simultaneous W_EN/R_EN with incrementing data -> COUNT stays 4, pointers wrap twice, output order preserved, no error flags.
4. FULL with W_EN=R_EN=1 -> read returns oldest word, write dropped, OVERFLOW=1, COUNT=7. Then CLR_ERR=1 with no error -> OVERFLOW=0.
5. Empty, R_EN=1 -> UNDERFLOW=1, O_VALID=0. Write 5 words, assert RST mid-stream -> next cycle COUNT=0, EMPTY=1, flags at reset values.
6. With SYNC_FIFO_FWFT_EN: write 0xA5 into empty FIFO -> next cycle O_VALID=1, O_DATA=0xA5 without R_EN. R_EN=1 -> following cycle O_VALID=0, EMPTY=1.
